// File: rtl/ac_button_conditioner_pkg.sv
// Shared types and widths for the button conditioner slice.
package ac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DELAY,
    REPEAT
  } btn_state_t;

  localparam int CMD_COUNT_W = 8;

endpackage

// File: rtl/ac_button_conditioner_if.sv
// Step-command handshake between the button conditioner and the temperature controller.
interface ac_button_conditioner_if;

  logic cmd_valid;
  logic cmd_up;
  logic cmd_ack;

  modport master (
    output cmd_valid,
    output cmd_up,
    input  cmd_ack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_up,
    output cmd_ack
  );

endinterface

// File: rtl/ac_button_conditioner_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer for one raw switch.
module ac_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] run;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      run   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // the flip happens on the last disagreeing sample of the run
      if (sync2 == clean) begin
        run <= '0;
      end else if (run == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean <= ~clean;
        run   <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_button_conditioner.sv
// Turns debounced up/down switches into handshaked step commands with hold auto-repeat.
module ac_button_conditioner
  import ac_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  ac_button_conditioner_if.master cmd,
  output logic                   conflict,
  output logic                   held,
  output logic [CMD_COUNT_W-1:0] cmd_count
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  logic up_db;
  logic dn_db;
  logic one_hot;
  logic hold_same;
  logic accept;

  btn_state_t       state;
  btn_state_t       state_nx;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_nx;
  logic             repeating;
  logic             rep_nx;
  logic             dir_nx;
  logic             valid_nx;
  logic             held_nx;

  ac_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_2 (clk_2),
    .reset (reset),
    .raw   (btn_up),
    .clean (up_db)
  );

  ac_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk_2 (clk_2),
    .reset (reset),
    .raw   (btn_down),
    .clean (dn_db)
  );

  assign one_hot   = up_db ^ dn_db;
  // cmd_up doubles as the latched direction of the current hold
  assign hold_same = cmd.cmd_up ? (up_db & ~dn_db) : (dn_db & ~up_db);
  assign accept    = cmd.cmd_valid & cmd.cmd_ack;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rpt_cnt       <= '0;
      repeating     <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_up    <= 1'b0;
      held          <= 1'b0;
      conflict      <= 1'b0;
      cmd_count     <= '0;
    end else begin
      state         <= state_nx;
      rpt_cnt       <= rpt_nx;
      repeating     <= rep_nx;
      cmd.cmd_valid <= valid_nx;
      cmd.cmd_up    <= dir_nx;
      held          <= held_nx;
      conflict      <= up_db & dn_db;
      cmd_count     <= cmd_count + CMD_COUNT_W'(accept);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (one_hot) state_nx = ISSUE;
      ISSUE:  if (accept) state_nx = hold_same ? (repeating ? REPEAT : DELAY) : IDLE;
      DELAY, REPEAT: begin
        if (!hold_same)           state_nx = IDLE;
        else if (rpt_cnt == '0)   state_nx = ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rpt_nx = rpt_cnt;
    rep_nx = repeating;
    dir_nx = cmd.cmd_up;
    case (state)
      IDLE: begin
        rep_nx = 1'b0;
        if (one_hot) dir_nx = up_db;
      end
      ISSUE: begin
        if (accept && hold_same) rpt_nx = repeating ? PERIOD_LOAD : DELAY_LOAD;
      end
      DELAY, REPEAT: begin
        if (rpt_cnt != '0)  rpt_nx = rpt_cnt - 1'b1;
        else if (hold_same) rep_nx = 1'b1;
      end
      default: ;
    endcase
    valid_nx = (state_nx == ISSUE);
    held_nx  = (state_nx == DELAY) || (state_nx == REPEAT);
  end

endmodule

// File: tb/tb_ac_button_conditioner.sv
// Randomised and directed bench for ac_button_conditioner against a deadline-based reference model.
module tb_ac_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_WAIT = 2;

  logic       clk_2;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       conflict;
  logic       held;
  logic [7:0] cmd_count;

  ac_button_conditioner_if bus();

  ac_button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .cmd       (bus),
    .conflict  (conflict),
    .held      (held),
    .cmd_count (cmd_count)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;

  // Reference model: switch state as delayed sample queues, commands as a deadline schedule.
  int m_mode, m_count, m_deadline, m_edge, m_up_run, m_dn_run;
  bit m_dir, m_rep, m_conflict, m_up_db, m_dn_db;
  bit up_pipe[$];
  bit dn_pipe[$];

  bit ack_auto;
  bit ack_noise;
  int ack_delay;
  int valid_age;

  function automatic void model_reset();
    m_mode = M_IDLE; m_count = 0; m_deadline = 0; m_up_run = 0; m_dn_run = 0;
    m_dir = 0; m_rep = 0; m_conflict = 0; m_up_db = 0; m_dn_db = 0;
    up_pipe = {1'b0, 1'b0};
    dn_pipe = {1'b0, 1'b0};
  endfunction

  function automatic void model_edge(bit ru, bit rdn, bit ack);
    bit ou, od, same, su, sd;
    ou = m_up_db;
    od = m_dn_db;
    m_edge++;
    same = m_dir ? (ou && !od) : (od && !ou);
    case (m_mode)
      M_IDLE: if (ou ^ od) begin m_mode = M_PEND; m_dir = ou; m_rep = 0; end
      M_PEND: if (ack) begin
        m_count++;
        if (same) begin m_mode = M_WAIT; m_deadline = m_edge + (m_rep ? RP : RD); end
        else begin m_mode = M_IDLE; m_rep = 0; end
      end
      default: if (!same) begin m_mode = M_IDLE; m_rep = 0; end
               else if (m_edge == m_deadline) begin m_mode = M_PEND; m_rep = 1; end
    endcase
    m_conflict = ou && od;
    su = up_pipe.pop_front(); up_pipe.push_back(ru);
    sd = dn_pipe.pop_front(); dn_pipe.push_back(rdn);
    m_up_run = (su != m_up_db) ? m_up_run + 1 : 0;
    if (m_up_run == DB) begin m_up_db = su; m_up_run = 0; end
    m_dn_run = (sd != m_dn_db) ? m_dn_run + 1 : 0;
    if (m_dn_run == DB) begin m_dn_db = sd; m_dn_run = 0; end
  endfunction

  task automatic step();
    @(posedge clk_2);
    if (reset) model_reset();
    else model_edge(btn_up, btn_down, bus.cmd_ack);
    #1;
    valid_age = bus.cmd_valid ? valid_age + 1 : 0;
    if (ack_auto)
      bus.cmd_ack = bus.cmd_valid ? (valid_age >= ack_delay)
                                  : (ack_noise && ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks += 5;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.cmd_valid); end
    if (bus.cmd_up !== 1'b0)    begin errors++; $display("FAIL reset_up got %0b exp 0", bus.cmd_up); end
    if (held !== 1'b0)          begin errors++; $display("FAIL reset_held got %0b exp 0", held); end
    if (conflict !== 1'b0)      begin errors++; $display("FAIL reset_conflict got %0b exp 0", conflict); end
    if (cmd_count !== 8'd0)     begin errors++; $display("FAIL reset_count got %0d exp 0", cmd_count); end
    @(negedge clk_2);
    reset = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", bus.cmd_valid); end
    end
  endtask

  task automatic test_single_press();
    int lat = -1;
    int rises = 0;
    bit prev = 0;
    bit up_at = 0;
    btn_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 11) btn_up = 1'b0;
      step();
      if (bus.cmd_valid && !prev) begin
        rises++;
        if (lat < 0) begin lat = i; up_at = bus.cmd_up; end
      end
      prev = bus.cmd_valid;
      checks++;
      if (bus.cmd_valid !== m_valid()) begin errors++; $display("FAIL single_valid cyc %0d got %0b exp %0b", i, bus.cmd_valid, m_valid()); end
    end
    checks += 4;
    if (lat !== 2 + DB + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, 2 + DB + 1); end
    if (up_at !== 1'b1)     begin errors++; $display("FAIL single_dir got %0b exp 1", up_at); end
    if (rises !== 1)        begin errors++; $display("FAIL single_cmds got %0d exp 1", rises); end
    if (cmd_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cmd_count); end
  endtask

  function automatic bit m_valid();
    return m_mode == M_PEND;
  endfunction

  task automatic test_bounce();
    int rises = 0;
    bit prev = 0;
    bit dir_at = 1;
    btn_down = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) btn_down = 1'b0;
      step();
      checks++;
      if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bounce_glitch cyc %0d got %0b exp 0", i, bus.cmd_valid); end
    end
    btn_down = 1'b1;
    for (int i = 0; i < 42; i++) begin
      if (i == 12) btn_down = 1'b0;
      step();
      if (bus.cmd_valid && !prev) begin rises++; dir_at = bus.cmd_up; end
      prev = bus.cmd_valid;
    end
    checks += 3;
    if (rises !== 1)        begin errors++; $display("FAIL bounce_cmds got %0d exp 1", rises); end
    if (dir_at !== 1'b0)    begin errors++; $display("FAIL bounce_dir got %0b exp 0", dir_at); end
    if (cmd_count !== 8'd2) begin errors++; $display("FAIL bounce_count got %0d exp 2", cmd_count); end
  endtask

  task automatic test_hold_repeat();
    int c0, n, nexp, exp_off;
    bit prev = 0;
    bit got;
    c0 = m_count;
    btn_up = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = (m_count != c0);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL hold_first_ack got none within 30 cycles exp 1"); end
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (bus.cmd_valid && !prev) begin
        exp_off = RD + n * (RP + ack_delay);
        checks++;
        if (i !== exp_off) begin errors++; $display("FAIL hold_repeat_time rep %0d at +%0d exp +%0d", n, i, exp_off); end
        n++;
      end
      prev = bus.cmd_valid;
      checks += 2;
      if (held !== !m_valid()) begin errors++; $display("FAIL hold_held cyc %0d got %0b exp %0b", i, held, !m_valid()); end
      if (cmd_count !== 8'(m_count)) begin errors++; $display("FAIL hold_count cyc %0d got %0d exp %0d", i, cmd_count, 8'(m_count)); end
    end
    nexp = 0;
    while (RD + nexp * (RP + ack_delay) <= 60) nexp++;
    checks++;
    if (n !== nexp) begin errors++; $display("FAIL hold_repeats got %0d exp %0d", n, nexp); end
    btn_up = 1'b0;
    repeat (30) step();
    checks += 2;
    if (held !== 1'b0)          begin errors++; $display("FAIL hold_release_held got %0b exp 0", held); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %0b exp 0", bus.cmd_valid); end
  endtask

  task automatic test_conflict();
    int rises = 0;
    bit prev;
    bit got = 0;
    btn_up = 1'b1;
    repeat (30) begin
      step();
      checks++;
      if (bus.cmd_valid !== m_valid()) begin errors++; $display("FAIL conf_pre_valid got %0b exp %0b", bus.cmd_valid, m_valid()); end
    end
    btn_down = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = m_conflict; end
    checks++;
    if (conflict !== 1'b1) begin errors++; $display("FAIL conf_flag got %0b exp 1", conflict); end
    prev = bus.cmd_valid;
    repeat (30) begin
      step();
      if (bus.cmd_valid && !prev) rises++;
      prev = bus.cmd_valid;
    end
    checks += 3;
    if (rises !== 0)            begin errors++; $display("FAIL conf_cmds got %0d exp 0", rises); end
    if (held !== 1'b0)          begin errors++; $display("FAIL conf_held got %0b exp 0", held); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL conf_valid got %0b exp 0", bus.cmd_valid); end
    btn_down = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = bus.cmd_valid; end
    checks += 3;
    if (!got)              begin errors++; $display("FAIL conf_resume got no command within 20 cycles exp 1"); end
    if (bus.cmd_up !== 1'b1) begin errors++; $display("FAIL conf_resume_dir got %0b exp 1", bus.cmd_up); end
    if (conflict !== 1'b0) begin errors++; $display("FAIL conf_clear got %0b exp 0", conflict); end
    btn_up = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_late_ack();
    int c0;
    ack_auto = 1'b0;
    c0 = m_count;
    bus.cmd_ack = 1'b1;
    repeat (5) step();
    bus.cmd_ack = 1'b0;
    checks++;
    if (cmd_count !== 8'(c0)) begin errors++; $display("FAIL stray_ack_count got %0d exp %0d", cmd_count, 8'(c0)); end
    btn_up = 1'b1;
    repeat (10) step();
    btn_up = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL late_hold cyc %0d got %0b exp 1", i, bus.cmd_valid); end
    end
    bus.cmd_ack = 1'b1;
    step();
    bus.cmd_ack = 1'b0;
    checks += 2;
    if (bus.cmd_valid !== 1'b0)   begin errors++; $display("FAIL late_drop got %0b exp 0", bus.cmd_valid); end
    if (cmd_count !== 8'(c0 + 1)) begin errors++; $display("FAIL late_count got %0d exp %0d", cmd_count, 8'(c0 + 1)); end
    repeat (5) step();
    checks += 2;
    if (held !== 1'b0)          begin errors++; $display("FAIL late_idle_held got %0b exp 0", held); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL late_idle_valid got %0b exp 0", bus.cmd_valid); end
    ack_auto = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    bit got = 0;
    ack_auto = 1'b0;
    bus.cmd_ack = 1'b0;
    btn_up = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin step(); got = bus.cmd_valid; end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_setup got no command within 20 cycles exp 1"); end
    btn_up = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b exp 0", bus.cmd_valid); end
    if (cmd_count !== 8'd0)     begin errors++; $display("FAIL rst_async_count got %0d exp 0", cmd_count); end
    if (held !== 1'b0)          begin errors++; $display("FAIL rst_async_held got %0b exp 0", held); end
    if (bus.cmd_up !== 1'b0)    begin errors++; $display("FAIL rst_async_up got %0b exp 0", bus.cmd_up); end
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
    valid_age = 0;
    ack_auto = 1'b1;
    repeat (20) begin
      step();
      checks++;
      if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %0b exp 0", bus.cmd_valid); end
    end
  endtask

  task automatic test_wrap();
    bit saw255 = 0;
    ack_delay = 1;
    btn_up = 1'b1;
    for (int i = 0; i < 4000 && m_count < 256; i++) begin
      step();
      if (cmd_count === 8'd255) saw255 = 1;
      checks++;
      if (cmd_count !== 8'(m_count)) begin errors++; $display("FAIL wrap_track got %0d exp %0d", cmd_count, 8'(m_count)); end
    end
    checks += 3;
    if (m_count != 256)     begin errors++; $display("FAIL wrap_budget got %0d commands exp 256", m_count); end
    if (!saw255)            begin errors++; $display("FAIL wrap_255 got never seen exp seen"); end
    if (cmd_count !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", cmd_count); end
    btn_up = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_random();
    int len;
    ack_noise = 1'b1;
    for (int seg = 0; seg < 80; seg++) begin
      btn_up    = ($urandom_range(0, 2) != 0);
      btn_down  = ($urandom_range(0, 3) == 0);
      ack_delay = $urandom_range(1, 4);
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) btn_up = ~btn_up;
        step();
        checks += 5;
        if (bus.cmd_valid !== m_valid())  begin errors++; $display("FAIL rnd_valid seg %0d got %0b exp %0b", seg, bus.cmd_valid, m_valid()); end
        if (bus.cmd_up !== m_dir)         begin errors++; $display("FAIL rnd_up seg %0d got %0b exp %0b", seg, bus.cmd_up, m_dir); end
        if (held !== (m_mode == M_WAIT))  begin errors++; $display("FAIL rnd_held seg %0d got %0b exp %0b", seg, held, m_mode == M_WAIT); end
        if (conflict !== m_conflict)      begin errors++; $display("FAIL rnd_conflict seg %0d got %0b exp %0b", seg, conflict, m_conflict); end
        if (cmd_count !== 8'(m_count))    begin errors++; $display("FAIL rnd_count seg %0d got %0d exp %0d", seg, cmd_count, 8'(m_count)); end
      end
    end
    ack_noise = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (30) step();
  endtask

  initial begin
    reset = 1'b1;
    btn_up = 1'b0;
    btn_down = 1'b0;
    bus.cmd_ack = 1'b0;
    ack_auto = 1'b1;
    ack_noise = 1'b0;
    ack_delay = 1;
    valid_age = 0;
    m_edge = 0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_repeat();
    test_conflict();
    test_late_ack();
    test_reset_mid_issue();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
